// File: rtl/pc_ir_status_unit.sv
// PC, instruction register and status register driven by the LEGv8 multi-cycle control word.
// Optional macro PC_ALIGN_CHECK_EN adds misaligned-PC trapping through the align_fault output.
`default_nettype none

module pc_ir_status_unit #(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          PS,
  input  logic                PCsel,
  input  logic                IL,
  input  logic                SL,
  input  logic [PC_WIDTH-1:0] reg_a,
  input  logic [PC_WIDTH-1:0] constant,
  input  logic [3:0]          alu_status,
  input  logic                alu_zero,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                imem_valid,
  output logic                stall,
`ifdef PC_ALIGN_CHECK_EN
  output logic                align_fault,
`endif
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic [31:0]         instruction,
  output logic [4:0]          status
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0]          PS_HOLD = 2'b00;
  localparam logic [1:0]          PS_INC  = 2'b01;
  localparam logic [1:0]          PS_LOAD = 2'b10;
  localparam logic [PC_WIDTH-1:0] FOUR    = PC_WIDTH'(4);

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [31:0]         instr_q;
  logic [3:0]          status_q;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] target_x4;
  logic                fault;
  logic                fetch_active;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;
  assign fault       = fault_q;
  assign align_fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign target    = PCsel ? constant : reg_a;
  assign target_x4 = {target[PC_WIDTH-3:0], 2'b00};
  assign pc_plus4  = pc_q + FOUR;

  always_comb begin
    pc_d = pc_q;
    case (PS)
      PS_HOLD: pc_d = pc_q;
      PS_INC:  pc_d = pc_plus4;
      PS_LOAD: pc_d = target;
      default: pc_d = pc_q + target_x4;
    endcase
  end

  // A fetch is in flight while waiting, or is being launched by IL from IDLE.
  // A faulted unit refuses new fetches.
  assign fetch_active = (state_q == WAIT) || (IL && !fault);
  assign imem_req     = fetch_active;
  assign imem_addr    = pc_q;
  assign stall        = fetch_active && !imem_valid;

  assign pc          = pc_q;
  assign instruction = instr_q;
  assign status      = {status_q, alu_zero};

  // Control fields are only consumed in cycles where the sequencer advances.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      status_q <= '0;
`ifdef PC_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
        if (PS != PS_HOLD) begin
          if (pc_d[1:0] != 2'b00) begin
            fault_q <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
`else
        pc_q <= pc_d;
`endif
        if (SL) begin
          status_q <= alu_status;
        end
        if (fetch_active) begin
          instr_q <= imem_data;
        end
      end
      state_q <= stall ? WAIT : IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_ir_status_unit.sv
// Directed self-checking bench for pc_ir_status_unit.
`default_nettype none

module tb_pc_ir_status_unit;

  localparam int PW = 64;

  logic          clock;
  logic          reset;
  logic [1:0]    PS;
  logic          PCsel;
  logic          IL;
  logic          SL;
  logic [PW-1:0] reg_a;
  logic [PW-1:0] constant;
  logic [3:0]    alu_status;
  logic          alu_zero;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_valid;
  logic          stall;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_plus4;
  logic [31:0]   instruction;
  logic [4:0]    status;
`ifdef PC_ALIGN_CHECK_EN
  logic          align_fault;
`endif

  int n_pass;
  int n_total;

  pc_ir_status_unit #(.PC_WIDTH(PW), .RESET_PC(64'h0)) dut (
    .clock      (clock),
    .reset      (reset),
    .PS         (PS),
    .PCsel      (PCsel),
    .IL         (IL),
    .SL         (SL),
    .reg_a      (reg_a),
    .constant   (constant),
    .alu_status (alu_status),
    .alu_zero   (alu_zero),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .stall      (stall),
`ifdef PC_ALIGN_CHECK_EN
    .align_fault(align_fault),
`endif
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instruction(instruction),
    .status     (status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    PS = 2'b00; PCsel = 1'b0; IL = 1'b0; SL = 1'b0;
    reg_a = '0; constant = '0; alu_status = 4'h0;
    imem_data = 32'h0; imem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    alu_zero = 1'b1;
    step(); step();
    n_total++; if (pc !== 64'h0) $display("FAIL reset_pc actual=%h required=%h", pc, 64'h0); else n_pass++;
    n_total++; if (instruction !== 32'h0) $display("FAIL reset_ir actual=%h required=%h", instruction, 32'h0); else n_pass++;
    n_total++; if (status !== 5'b00001) $display("FAIL reset_status actual=%b required=%b", status, 5'b00001); else n_pass++;
    n_total++; if ({stall, imem_req} !== 2'b00) $display("FAIL reset_stall_req actual=%b required=%b", {stall, imem_req}, 2'b00); else n_pass++;
    alu_zero = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_zero_wait();
    IL = 1'b1; PS = 2'b01; imem_data = 32'h91000421; imem_valid = 1'b1;
    #1;
    n_total++; if ({imem_req, stall} !== 2'b10) $display("FAIL zw_req_stall actual=%b required=%b", {imem_req, stall}, 2'b10); else n_pass++;
    n_total++; if (imem_addr !== 64'h0) $display("FAIL zw_addr actual=%h required=%h", imem_addr, 64'h0); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (instruction !== 32'h91000421) $display("FAIL zw_ir actual=%h required=%h", instruction, 32'h91000421); else n_pass++;
    n_total++; if (pc !== 64'h4) $display("FAIL zw_pc actual=%h required=%h", pc, 64'h4); else n_pass++;
  endtask

  task automatic test_wait_fetch();
    IL = 1'b1; PS = 2'b01; imem_data = 32'hDEADBEEF; imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if ({stall, imem_req} !== 2'b11) $display("FAIL wait_stall_%0d actual=%b required=%b", i, {stall, imem_req}, 2'b11); else n_pass++;
      n_total++; if (imem_addr !== 64'h4) $display("FAIL wait_addr_%0d actual=%h required=%h", i, imem_addr, 64'h4); else n_pass++;
      step();
      n_total++; if (pc !== 64'h4) $display("FAIL wait_pc_%0d actual=%h required=%h", i, pc, 64'h4); else n_pass++;
    end
    imem_valid = 1'b1;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL wait_release actual=%b required=%b", stall, 1'b0); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (pc !== 64'h8) $display("FAIL wait_pc_done actual=%h required=%h", pc, 64'h8); else n_pass++;
    n_total++; if (instruction !== 32'hDEADBEEF) $display("FAIL wait_ir actual=%h required=%h", instruction, 32'hDEADBEEF); else n_pass++;
    #1;
    n_total++; if ({stall, imem_req} !== 2'b00) $display("FAIL wait_back_idle actual=%b required=%b", {stall, imem_req}, 2'b00); else n_pass++;
  endtask

  task automatic test_branch_rel();
    PS = 2'b10; PCsel = 1'b1; constant = 64'h100;
    step();
    n_total++; if (pc !== 64'h100) $display("FAIL brel_setup actual=%h required=%h", pc, 64'h100); else n_pass++;
    PS = 2'b11; PCsel = 1'b1; constant = 64'hFFFF_FFFF_FFFF_FFFE; reg_a = 64'h1234;
    step();
    idle_inputs();
    n_total++; if (pc !== 64'hF8) $display("FAIL brel_pc actual=%h required=%h", pc, 64'hF8); else n_pass++;
  endtask

  task automatic test_branch_reg();
    PS = 2'b10; PCsel = 1'b0; reg_a = 64'h2000; constant = 64'h40;
    #1;
    n_total++; if (pc_plus4 !== 64'hFC) $display("FAIL breg_plus4 actual=%h required=%h", pc_plus4, 64'hFC); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (pc !== 64'h2000) $display("FAIL breg_pc actual=%h required=%h", pc, 64'h2000); else n_pass++;
    n_total++; if (pc_plus4 !== 64'h2004) $display("FAIL breg_plus4_new actual=%h required=%h", pc_plus4, 64'h2004); else n_pass++;
  endtask

  task automatic test_status();
    SL = 1'b1; alu_status = 4'b1010; alu_zero = 1'b0;
    step();
    n_total++; if (status !== 5'b10100) $display("FAIL st_load actual=%b required=%b", status, 5'b10100); else n_pass++;
    SL = 1'b0; alu_status = 4'b0101;
    step();
    n_total++; if (status !== 5'b10100) $display("FAIL st_hold actual=%b required=%b", status, 5'b10100); else n_pass++;
    alu_zero = 1'b1;
    #1;
    n_total++; if (status !== 5'b10101) $display("FAIL st_zraw_hi actual=%b required=%b", status, 5'b10101); else n_pass++;
    alu_zero = 1'b0;
    #1;
    n_total++; if (status !== 5'b10100) $display("FAIL st_zraw_lo actual=%b required=%b", status, 5'b10100); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_il_sl_combined();
    IL = 1'b1; SL = 1'b1; PS = 2'b01; alu_status = 4'b0011; imem_data = 32'hCAFE0001; imem_valid = 1'b0;
    step();
    n_total++; if (status !== 5'b10100) $display("FAIL ilsl_stalled_status actual=%b required=%b", status, 5'b10100); else n_pass++;
    imem_valid = 1'b1;
    step();
    idle_inputs();
    n_total++; if (status !== 5'b00110) $display("FAIL ilsl_status actual=%b required=%b", status, 5'b00110); else n_pass++;
    n_total++; if (pc !== 64'h2004) $display("FAIL ilsl_pc actual=%h required=%h", pc, 64'h2004); else n_pass++;
    n_total++; if (instruction !== 32'hCAFE0001) $display("FAIL ilsl_ir actual=%h required=%h", instruction, 32'hCAFE0001); else n_pass++;
  endtask

  task automatic test_back_to_back();
    IL = 1'b1; PS = 2'b10; PCsel = 1'b0; reg_a = 64'h40; imem_data = 32'hAAAA0001; imem_valid = 1'b1;
    #1;
    n_total++; if (imem_addr !== 64'h2004) $display("FAIL b2b_addr0 actual=%h required=%h", imem_addr, 64'h2004); else n_pass++;
    step();
    PS = 2'b01; imem_data = 32'hBBBB0002;
    #1;
    n_total++; if (imem_addr !== 64'h40) $display("FAIL b2b_addr1 actual=%h required=%h", imem_addr, 64'h40); else n_pass++;
    n_total++; if (instruction !== 32'hAAAA0001) $display("FAIL b2b_ir0 actual=%h required=%h", instruction, 32'hAAAA0001); else n_pass++;
    step();
    idle_inputs();
    n_total++; if (instruction !== 32'hBBBB0002) $display("FAIL b2b_ir1 actual=%h required=%h", instruction, 32'hBBBB0002); else n_pass++;
    n_total++; if (pc !== 64'h44) $display("FAIL b2b_pc actual=%h required=%h", pc, 64'h44); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    IL = 1'b1; PS = 2'b01; imem_data = 32'h55550000; imem_valid = 1'b0;
    step();
    n_total++; if (stall !== 1'b1) $display("FAIL rmw_in_wait actual=%b required=%b", stall, 1'b1); else n_pass++;
    IL = 1'b0; PS = 2'b00;
    reset = 1'b0;
    #1;
    n_total++; if (pc !== 64'h0) $display("FAIL rmw_pc_async actual=%h required=%h", pc, 64'h0); else n_pass++;
    n_total++; if ({stall, imem_req} !== 2'b00) $display("FAIL rmw_idle actual=%b required=%b", {stall, imem_req}, 2'b00); else n_pass++;
    step();
    reset = 1'b1;
    imem_valid = 1'b1;
    step();
    n_total++; if (instruction !== 32'h0) $display("FAIL rmw_late_ir actual=%h required=%h", instruction, 32'h0); else n_pass++;
    n_total++; if (pc !== 64'h0) $display("FAIL rmw_late_pc actual=%h required=%h", pc, 64'h0); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_misalign();
    PS = 2'b10; PCsel = 1'b0; reg_a = 64'h2002;
    step();
    idle_inputs();
`ifdef PC_ALIGN_CHECK_EN
    n_total++; if (pc !== 64'h0) $display("FAIL mis_pc_hold actual=%h required=%h", pc, 64'h0); else n_pass++;
    n_total++; if (align_fault !== 1'b1) $display("FAIL mis_fault actual=%b required=%b", align_fault, 1'b1); else n_pass++;
    IL = 1'b1; imem_valid = 1'b0;
    #1;
    n_total++; if ({imem_req, stall} !== 2'b00) $display("FAIL mis_refuse actual=%b required=%b", {imem_req, stall}, 2'b00); else n_pass++;
    idle_inputs();
`else
    n_total++; if (pc !== 64'h2002) $display("FAIL mis_pc_load actual=%h required=%h", pc, 64'h2002); else n_pass++;
`endif
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_zero_wait();
    test_wait_fetch();
    test_branch_rel();
    test_branch_reg();
    test_status();
    test_il_sl_combined();
    test_back_to_back();
    test_reset_mid_wait();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
